// File: rtl/packet_rr_arbiter.sv
// Round-robin packet arbiter: grants one packetizer source at a time, forwards
// its beats onto a shared link with one cycle of latency, enforces an
// inter-packet gap and aborts packets whose source stalls for too long.
module packet_rr_arbiter #(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned GAP_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_SRC-1:0]        src_req,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_valid,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_eof,
  output logic [DATA_W-1:0]         dout,
  output logic                      valid,
  output logic                      eof,
  output logic [2:0]                src_id,
  output logic                      timeout_err,
  output logic                      stray_beat
);

  localparam int unsigned IdxW  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CandW = IdxW + 1;

  typedef enum logic [1:0] {StIdle, StStart, StXfer, StGap} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [15:0]         wd_q, wd_d;
  logic [7:0]          gap_q, gap_d;

  logic [NUM_SRC-1:0]  ready_q, ready_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                valid_q, valid_d;
  logic                eof_q, eof_d;
  logic [2:0]          id_q, id_d;
  logic                timeout_q, timeout_d;
  logic                stray_q, stray_d;

  logic                found;
  logic [IdxW-1:0]     winner;
  logic [CandW-1:0]    cand;
  logic [DATA_W-1:0]   sel_data;
  logic                sel_valid;
  logic                sel_eof;
  logic [NUM_SRC-1:0]  own_mask;

  // Rotating priority search starting just after the last granted source.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last_q} + CandW'(k);
      if (cand >= CandW'(NUM_SRC)) begin
        cand = cand - CandW'(NUM_SRC);
      end
      if (!found && src_req[cand[IdxW-1:0]]) begin
        found  = 1'b1;
        winner = cand[IdxW-1:0];
      end
    end
  end

  // Select the granted source's beat and flag which source currently owns the link.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    sel_eof   = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IdxW'(i)) begin
        sel_data  = src_data[i*DATA_W +: DATA_W];
        sel_valid = src_valid[i];
        sel_eof   = src_eof[i];
      end
    end
    own_mask = '0;
    // Only an active packet owns the link; in IDLE and GAP every beat is stray.
    if (state_q == StStart || state_q == StXfer) begin
      own_mask[grant_q] = 1'b1;
    end
  end

  // Next-state and registered-output logic; outputs default to 0 each cycle.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wd_d      = wd_q;
    gap_d     = gap_q;
    ready_d   = '0;
    dout_d    = '0;
    valid_d   = 1'b0;
    eof_d     = 1'b0;
    id_d      = '0;
    timeout_d = 1'b0;
    stray_d   = |(src_valid & ~own_mask);

    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d         = winner;
          last_d          = winner;
          // Pulse is visible during the START cycle.
          ready_d[winner] = 1'b1;
          state_d         = StStart;
        end
      end
      StStart: begin
        wd_d    = '0;
        state_d = StXfer;
      end
      StXfer: begin
        // A granted beat beats a simultaneous watchdog expiry.
        if (sel_valid) begin
          dout_d  = sel_data;
          valid_d = 1'b1;
          eof_d   = sel_eof;
          id_d    = 3'(grant_q);
          wd_d    = '0;
          if (sel_eof) begin
            gap_d   = '0;
            state_d = StGap;
          end
        end else if (wd_q == 16'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          gap_d     = '0;
          state_d   = StGap;
        end else begin
          wd_d = wd_q + 16'd1;
        end
      end
      StGap: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= IdxW'(NUM_SRC - 1);
      wd_q      <= '0;
      gap_q     <= '0;
      ready_q   <= '0;
      dout_q    <= '0;
      valid_q   <= 1'b0;
      eof_q     <= 1'b0;
      id_q      <= '0;
      timeout_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      wd_q      <= wd_d;
      gap_q     <= gap_d;
      ready_q   <= ready_d;
      dout_q    <= dout_d;
      valid_q   <= valid_d;
      eof_q     <= eof_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
      stray_q   <= stray_d;
    end
  end

  assign src_ready   = ready_q;
  assign dout        = dout_q;
  assign valid       = valid_q;
  assign eof         = eof_q;
  assign src_id      = id_q;
  assign timeout_err = timeout_q;
  assign stray_beat  = stray_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: directed packet scenarios, a cycle-stamp
// reference model compared every cycle, and literal checks on key timings.
module tb_packet_rr_arbiter;

  localparam int NS  = 4;
  localparam int DW  = 64;
  localparam int GAP = 4;
  localparam int TO  = 1024;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NS-1:0]     src_req = '0;
  logic [NS-1:0]     src_ready;
  logic [NS-1:0]     src_valid = '0;
  logic [NS*DW-1:0]  src_data;
  logic [NS-1:0]     src_eof = '0;
  logic [DW-1:0]     dout;
  logic              valid, eof, timeout_err, stray_beat;
  logic [2:0]        src_id;
  logic [DW-1:0]     sdata [NS];

  int nvec = 0;
  int nfail = 0;
  int cyc = 0;

  packet_rr_arbiter #(
    .NUM_SRC(NS), .DATA_W(DW), .GAP_CYCLES(GAP), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .src_req(src_req), .src_ready(src_ready),
    .src_valid(src_valid), .src_data(src_data), .src_eof(src_eof),
    .dout(dout), .valid(valid), .eof(eof), .src_id(src_id),
    .timeout_err(timeout_err), .stray_beat(stray_beat)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = sdata[i];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the link is owned by at most one source; timing is kept
  // as absolute edge numbers (when beats may start, last beat, when link frees).
  logic [NS-1:0] e_ready = '0;
  logic [DW-1:0] e_dout = '0;
  logic          e_valid = 1'b0, e_eof = 1'b0, e_to = 1'b0, e_stray = 1'b0;
  logic [2:0]    e_id = '0;
  logic [NS-1:0] m_own;
  int m_owner = -1, m_last = NS - 1, m_t = 0, m_free = 0, m_xfer_from = 0, m_last_beat = 0;
  int m_c;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_owner = -1; m_last = NS - 1; m_t = 0; m_free = 0;
      m_xfer_from = 0; m_last_beat = 0;
      e_ready = '0; e_dout = '0; e_valid = 0; e_eof = 0; e_id = '0; e_to = 0; e_stray = 0;
    end else begin
      e_ready = '0; e_dout = '0; e_valid = 0; e_eof = 0; e_id = '0; e_to = 0;
      m_own = '0;
      if (m_owner >= 0) m_own[m_owner] = 1'b1;
      e_stray = |(src_valid & ~m_own);
      if (m_owner < 0) begin
        if (m_t >= m_free) begin
          for (int k = 1; k <= NS; k++) begin
            m_c = (m_last + k) % NS;
            if (m_owner < 0 && src_req[m_c]) m_owner = m_c;
          end
          if (m_owner >= 0) begin
            m_last = m_owner;
            e_ready[m_owner] = 1'b1;
            m_xfer_from = m_t + 2;
            m_last_beat = m_t + 1;
          end
        end
      end else if (m_t >= m_xfer_from) begin
        if (src_valid[m_owner]) begin
          e_dout = sdata[m_owner]; e_valid = 1; e_eof = src_eof[m_owner];
          e_id = 3'(m_owner); m_last_beat = m_t;
          if (src_eof[m_owner]) begin m_owner = -1; m_free = m_t + GAP + 1; end
        end else if (m_t - m_last_beat == TO) begin
          e_to = 1; m_owner = -1; m_free = m_t + GAP + 1;
        end
      end
      m_t++;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("cmp_valid", valid, e_valid);
    check("cmp_eof", eof, e_eof);
    check("cmp_dout", dout, e_dout);
    check("cmp_src_id", src_id, e_id);
    check("cmp_src_ready", src_ready, e_ready);
    check("cmp_timeout_err", timeout_err, e_to);
    check("cmp_stray_beat", stray_beat, e_stray);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_src();
    src_valid = '0; src_eof = '0;
    for (int i = 0; i < NS; i++) sdata[i] = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; src_req = '0; clear_src();
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic wait_ready(output int idx, output int at);
    idx = -1; at = 0;
    for (int k = 0; k < 2000 && idx < 0; k++) begin
      step();
      for (int i = 0; i < NS; i++) if (src_ready[i]) begin idx = i; at = cyc; end
    end
    if (idx < 0) begin
      nvec++; nfail++;
      $display("FAIL wait_ready: got no src_ready, expected a grant within 2000 cycles");
    end
  endtask

  // Called right after src_ready is seen: skips the START cycle, then streams beats.
  task automatic send_pkt(input int s, input int exp_id, input int n,
                          input logic [DW-1:0] base, input bit last_eof);
    step();
    for (int i = 0; i < n; i++) begin
      src_valid[s] = 1'b1; sdata[s] = base + DW'(i);
      src_eof[s] = last_eof && (i == n - 1);
      step();
      check("pkt_dout", dout, base + DW'(i));
      check("pkt_valid", valid, 1);
      check("pkt_src_id", src_id, exp_id);
      check("pkt_eof", eof, (last_eof && i == n - 1) ? 1 : 0);
    end
    clear_src();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, expected bench end before time limit");
    $fatal(1, "bench time limit");
  end

  initial begin
    int idx, at, t0, te, tc, eof_at, strays;
    int rr_exp [6] = '{0, 1, 2, 3, 0, 1};
    clear_src();
    #1;
    do_reset();
    check("reset_valid", valid, 0);
    check("reset_src_ready", src_ready, 0);

    // Single source, three beats A,B,C, then the enforced gap.
    src_req = 4'b0001; t0 = cyc;
    wait_ready(idx, at);
    check("t1_grant_src", idx, 0);
    check("t1_ready_latency", at - t0, 1);
    send_pkt(0, 0, 3, 64'hA000_0000_0000_00A0, 1'b1);
    te = cyc;
    wait_ready(idx, at);
    check("t1_regrant_src", idx, 0);
    check("t1_gap_to_ready", at - te, GAP + 1);
    src_req = '0;
    if (idx >= 0) send_pkt(idx, 0, 1, 64'hA000_0000_0000_00D0, 1'b1);
    repeat (8) step();

    // Round robin with all sources requesting.
    do_reset();
    src_req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      wait_ready(idx, at);
      if (n == 5) src_req = '0;
      check("rr_grant_order", idx, rr_exp[n]);
      if (idx >= 0) send_pkt(idx, rr_exp[n], 1, 64'hB000_0000_0000_0000 + DW'(n << 4), 1'b1);
    end
    repeat (8) step();

    // Source 2 sends one beat and stalls; source 3 waits behind it.
    do_reset();
    src_req = 4'b1100;
    wait_ready(idx, at);
    check("to_grant_src", idx, 2);
    src_req = 4'b1000;
    send_pkt(2, 2, 1, 64'hC000_0000_0000_0001, 1'b0);
    t0 = cyc; tc = -1; eof_at = 0;
    for (int k = 0; k < 1100 && tc < 0; k++) begin
      step();
      if (timeout_err) begin tc = cyc; eof_at = eof; end
    end
    check("to_delay", tc - t0, TO);
    check("to_no_eof", eof_at, 0);
    wait_ready(idx, at);
    check("to_next_src", idx, 3);
    check("to_gap_to_ready", at - tc, GAP + 1);
    src_req = '0;
    if (idx >= 0) send_pkt(idx, 3, 1, 64'hC000_0000_0000_0030, 1'b1);
    repeat (8) step();

    // Source 3 drives stray beats while source 1 streams.
    do_reset();
    src_req = 4'b0010;
    wait_ready(idx, at);
    check("stray_grant_src", idx, 1);
    src_req = '0; strays = 0;
    step();
    for (int i = 0; i < 4; i++) begin
      src_valid[1] = 1'b1; sdata[1] = 64'hD100_0000_0000_0000 + DW'(i); src_eof[1] = (i == 3);
      src_valid[3] = (i == 1 || i == 2); sdata[3] = 64'hDEAD_BEEF_DEAD_BEEF; src_eof[3] = 1'b1;
      step();
      check("stray_dout", dout, 64'hD100_0000_0000_0000 + DW'(i));
      check("stray_src_id", src_id, 1);
      if (stray_beat) strays++;
    end
    clear_src();
    for (int i = 0; i < 3; i++) begin step(); if (stray_beat) strays++; end
    check("stray_pulse_count", strays, 2);
    repeat (6) step();

    // Granted eof arrives exactly when the watchdog would expire.
    do_reset();
    src_req = 4'b0001;
    wait_ready(idx, at);
    src_req = '0;
    send_pkt(0, 0, 1, 64'hE000_0000_0000_0001, 1'b0);
    repeat (TO - 1) step();
    src_valid[0] = 1'b1; sdata[0] = 64'hE000_0000_0000_00FF; src_eof[0] = 1'b1;
    step();
    check("coll_valid", valid, 1);
    check("coll_eof", eof, 1);
    check("coll_dout", dout, 64'hE000_0000_0000_00FF);
    check("coll_timeout_err", timeout_err, 0);
    clear_src();
    step();
    check("coll_timeout_after", timeout_err, 0);
    repeat (8) step();

    // Reset asserted while source 1's second beat is on the link.
    do_reset();
    src_req = 4'b0010;
    wait_ready(idx, at);
    check("mrst_grant_src", idx, 1);
    src_req = 4'b0011;
    step();
    src_valid[1] = 1'b1; sdata[1] = 64'hF100_0000_0000_0000;
    step();
    sdata[1] = 64'hF100_0000_0000_0001;
    step();
    check("mrst_beat2_valid", valid, 1);
    reset = 1'b1;
    #1;
    check("mrst_valid", valid, 0);
    check("mrst_eof", eof, 0);
    check("mrst_src_ready", src_ready, 0);
    check("mrst_dout", dout, 0);
    clear_src();
    repeat (2) step();
    reset = 1'b0;
    src_req = 4'b0011;
    wait_ready(idx, at);
    check("mrst_first_grant", idx, 0);
    src_req = '0;
    if (idx >= 0) send_pkt(idx, 0, 1, 64'hF000_0000_0000_0000, 1'b1);
    repeat (10) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Round-robin scheduler sharing one 64-bit packet output link between NUM_SRC packetizer instances.
- Each packetizer waits in idle until it receives a one-cycle ready pulse, then streams valid/data beats ending in an eof beat.
- This block decides which source may start a packet and issues that source's ready pulse.
- It muxes the granted stream onto the shared link, enforces an inter-packet gap, and recovers from stalled sources with a timeout.

Parameters:
- NUM_SRC, 4, number of packetizer sources (2..8).
- DATA_W, 64, beat width.
- GAP_CYCLES, 4, idle cycles forced on the output after each packet end (1..255).
- TIMEOUT, 1024, maximum cycles between consecutive granted beats before the packet is aborted (16-bit).

Ports:
- clk  in  1  single clock domain.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- src_req  in  NUM_SRC  per-source request; high means the source has data buffered.
- src_ready  out  NUM_SRC  one-hot single-cycle start pulse to the granted source.
- src_valid  in  NUM_SRC  per-source beat valid.
- src_data  in  NUM_SRC*DATA_W  concatenated beats; source i occupies bits [i*DATA_W +: DATA_W].
- src_eof  in  NUM_SRC  per-source last-beat flag, qualified by src_valid.
- dout  out  DATA_W  output beat.
- valid  out  1  output beat valid.
- eof  out  1  output last beat.
- src_id  out  3  index of the source owning the current output beat.
- timeout_err  out  1  one-cycle pulse when a packet is aborted.
- stray_beat  out  1  one-cycle pulse when any non-granted source asserts src_valid.

Behaviour:
- Reset (asynchronous) values:
  - src_ready=0, dout=0, valid=0, eof=0, src_id=0, timeout_err=0, stray_beat=0.
  - state=IDLE, last_grant=NUM_SRC-1, so source 0 has first priority.
- All outputs are registered. When they are not being driven, each cycle defaults them to 0.
- States:
  - IDLE:
    - Search src_req starting from (last_grant+1) mod NUM_SRC and wrapping; the first set bit wins.
    - With no request, stay in IDLE.
    - Otherwise latch grant=winner, set last_grant=winner, go to START.
  - START (exactly 1 cycle):
    - src_ready[grant]=1.
    - Clear the watchdog counter.
    - Go to XFER.
  - XFER:
    - Each cycle with src_valid[grant]=1, on the next cycle: dout=src_data[grant], valid=1, eof=src_eof[grant], src_id=grant. Latency is 1 clock.
    - Each accepted beat clears the watchdog; otherwise the watchdog increments.
    - On a beat with src_eof[grant]=1, go to GAP. That eof beat is still forwarded.
    - When the watchdog reaches TIMEOUT-1 with no beat: timeout_err=1 the next cycle, no eof is generated, go to GAP.
  - GAP:
    - Hold outputs at 0 for exactly GAP_CYCLES cycles, then go to IDLE.
    - src_valid from the just-finished source is ignored and counts as stray.
- Fairness: a source re-requesting immediately after its own packet is served last among the current requesters.
- Request changes:
  - src_req changes after the grant has no effect on the current packet.
  - A request deasserted before IDLE samples it is not granted.
- Stray beats: src_valid on any source other than grant, in any state, causes stray_beat=1 on the next cycle. The beat is dropped and never reaches dout.
- Simultaneous events in one cycle:
  - Granted eof and watchdog expiry together: the eof wins, the beat is forwarded, and timeout_err stays 0.
  - Granted beat and stray beat together: the granted beat is forwarded and stray_beat is also pulsed.
- Reset asserted mid-packet:
  - Outputs drop to 0 immediately (asynchronously).
  - The partial packet is not terminated with eof.
  - After release, arbitration restarts from source 0.
- Unused src_id bits (above clog2(NUM_SRC)) are driven 0.

Test Plan:
- Single source: src_req=4'b0001; source 0 sends 3 beats (A,B,C), with eof on C. Required:
  - src_ready[0] is pulsed 1 cycle after IDLE sees the request.
  - dout shows A,B,C, each 1 cycle after its src_valid, with src_id=0 and eof only on C.
  - After C, output stays idle for 4 cycles before the next src_ready.
- Round-robin: src_req=4'b1111 held; each source sends 1-beat packets. Required: grant order 0,1,2,3,0,1 and src_id follows the same order.
- Timeout: source 2 granted, sends 1 beat, then stalls. Required:
  - timeout_err pulses exactly 1024 cycles after that beat; no eof is issued.
  - Source 3 is granted after the 4-cycle gap.
- Stray: while source 1 is streaming, source 3 asserts src_valid for 2 cycles. Required:
  - stray_beat pulses for 2 cycles.
  - The source-1 data on dout is uncorrupted.
- Collision: the granted eof arrives on the same cycle the watchdog expires. Required: eof=1 forwarded and timeout_err=0.
- Mid-packet reset: reset asserted during source 1's 2nd beat. Required:
  - valid/eof/src_ready are 0 in the same cycle.
  - After release with src_req=4'b0011, source 0 is granted first.
